// File: rtl/mix_columns_engine.sv
// Iterative MixColumns / InvMixColumns engine for an NB-column Rijndael state.
// Transforms COLS_PER_CYCLE columns per clock in place and holds the result until accepted.
module mix_columns_engine #(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            in_inv_i,
    input  logic [32*NB-1:0] in_state_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [32*NB-1:0] out_state_o,
    output logic            busy_o
);

    localparam int SW = 32 * NB;
    localparam int IW = 4;
    localparam logic [IW-1:0] STEP = IW'(COLS_PER_CYCLE);
    localparam logic [IW-1:0] LAST = IW'(NB - COLS_PER_CYCLE);

    generate
        if (NB < 4 || NB > 8 || COLS_PER_CYCLE < 1 || (NB % COLS_PER_CYCLE) != 0) begin : g_bad_param
            $error("mix_columns_engine: illegal NB/COLS_PER_CYCLE combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [IW-1:0]    col_idx_q;
    logic             inv_q;
    logic [SW-1:0]    data_q;
    logic [SW-1:0]    data_d;
    logic [SW-1:0]    out_state_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             in_ready_q;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the forward or inverse matrix; all products from chained xtime.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (inv) begin
                res[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                                 ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                                 ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                                 ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
            end else begin
                res[31-8*i -: 8] = x2[i]
                                 ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                                 ^ a[(i+2)%4]
                                 ^ a[(i+3)%4];
            end
        end
        return res;
    endfunction

    // Next working state: the current group of columns transformed in place.
    always_comb begin
        data_d = data_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            data_d[SW-1-32*(int'(col_idx_q)+k) -: 32] =
                mix_col(data_q[SW-1-32*(int'(col_idx_q)+k) -: 32], inv_q);
        end
    end

    // Control FSM with registered handshake outputs; result is copied out only when complete.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            col_idx_q   <= '0;
            inv_q       <= 1'b0;
            data_q      <= '0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        data_q     <= in_state_i;
                        inv_q      <= in_inv_i;
                        col_idx_q  <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    data_q <= data_d;
                    if (col_idx_q == LAST) begin
                        col_idx_q   <= '0;
                        out_state_q <= data_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        col_idx_q <= col_idx_q + STEP;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_state_q <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    col_idx_q   <= '0;
                    out_state_q <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready must read low for the whole time reset is held, not just after the first edge.
    assign in_ready_o  = in_ready_q & rst_ni;
    assign out_valid_o = out_valid_q;
    assign out_state_o = out_state_q;
    assign busy_o      = busy_q;

endmodule
